// File: rtl/alu_pkg.sv
// Shared types and constants for the add/sub arbiter slice.
package alu_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int unsigned OPND_W = 3;
    localparam int unsigned RES_W  = 4;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_t;

    // True when a sign-magnitude result has zero magnitude, whatever its sign bit.
    function automatic logic is_zero_mag(input logic [RES_W-1:0] r);
        return r[RES_W-2:0] == '0;
    endfunction

endpackage

// File: rtl/add_sub.sv
// Sign-magnitude add/sub execution unit. Equal-magnitude cancellation keeps A's sign,
// so it can emit -0; DZF flags that case.
module add_sub
    import alu_pkg::*;
(
    input  logic              OP,
    input  logic [OPND_W-1:0] A,
    input  logic [OPND_W-1:0] B,
    output logic [RES_W-1:0]  R,
    output logic              ZF,
    output logic              SF,
    output logic              DZF
);

    logic       w_b_sign;
    logic [2:0] w_a_mag;
    logic [2:0] w_b_mag;

    assign w_b_sign = B[2] ^ (OP == OP_SUB);
    assign w_a_mag  = {1'b0, A[1:0]};
    assign w_b_mag  = {1'b0, B[1:0]};

    // Magnitude add when effective signs agree, otherwise subtract smaller from larger.
    always_comb begin
        R = '0;
        if (A[2] == w_b_sign) begin
            R = {A[2], w_a_mag + w_b_mag};
        end else if (w_a_mag >= w_b_mag) begin
            R = {A[2], w_a_mag - w_b_mag};
        end else begin
            R = {w_b_sign, w_b_mag - w_a_mag};
        end
    end

    assign ZF  = is_zero_mag(R);
    assign SF  = R[3];
    assign DZF = ZF & R[3];

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the last winner loses the next tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_take,
    output logic       o_valid,
    output logic       o_id
);

    logic r_last;

    assign o_valid = |i_req;
    assign o_id    = (&i_req) ? ~r_last : i_req[1];

    // Remember who won; reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (i_take) begin
            r_last <= o_id;
        end
    end

endmodule

// File: rtl/alu_addsub_arbiter.sv
// Shares one add_sub unit between two requesters with a single response channel.
module alu_addsub_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_op,
    input  logic [OPND_W-1:0] req0_a,
    input  logic [OPND_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_op,
    input  logic [OPND_W-1:0] req1_a,
    input  logic [OPND_W-1:0] req1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [RES_W-1:0]  rsp_r,
    output logic              rsp_zf,
    output logic              rsp_sf
);

    localparam logic [2:0] LAST_CNT = 3'(EXEC_CYCLES);

    state_t            r_state;
    state_t            w_state_next;
    logic              w_gnt_valid;
    logic              w_gnt_id;
    logic              w_take;
    logic              w_capture;
    logic              w_release;
    logic              r_op;
    logic              r_id;
    logic [OPND_W-1:0] r_a;
    logic [OPND_W-1:0] r_b;
    logic [2:0]        r_cnt;
    logic [RES_W-1:0]  w_r;
    logic              w_zf;
    logic              w_sf;
    logic              w_dzf_unused;
    logic              r_rsp_valid;
    logic              r_rsp_id;
    logic [RES_W-1:0]  r_rsp_r;
    logic              r_rsp_zf;
    logic              r_rsp_sf;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .i_req   ({req1_valid, req0_valid}),
        .i_take  (w_take),
        .o_valid (w_gnt_valid),
        .o_id    (w_gnt_id)
    );

    add_sub u_add_sub (
        .OP  (r_op),
        .A   (r_a),
        .B   (r_b),
        .R   (w_r),
        .ZF  (w_zf),
        .SF  (w_sf),
        .DZF (w_dzf_unused)
    );

    // Next-state and handshake strobes; accepts are suppressed while reset is held.
    always_comb begin
        w_state_next = r_state;
        w_take       = 1'b0;
        w_capture    = 1'b0;
        w_release    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_gnt_valid && !rst) begin
                    w_take       = 1'b1;
                    w_state_next = StExec;
                end
            end
            StExec: begin
                if (r_cnt == LAST_CNT) begin
                    w_capture    = 1'b1;
                    w_state_next = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    w_release    = 1'b1;
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign req0_ready = w_take & ~w_gnt_id;
    assign req1_ready = w_take &  w_gnt_id;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Latch the granted requester's operation in the accept cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op <= OP_ADD;
            r_id <= 1'b0;
            r_a  <= '0;
            r_b  <= '0;
        end else if (w_take) begin
            r_op <= w_gnt_id ? req1_op : req0_op;
            r_id <= w_gnt_id;
            r_a  <= w_gnt_id ? req1_a  : req0_a;
            r_b  <= w_gnt_id ? req1_b  : req0_b;
        end
    end

    // Execution counter: 1 on the first EXEC cycle, capture when it reaches EXEC_CYCLES.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_take) begin
            r_cnt <= 3'd1;
        end else if (w_capture) begin
            r_cnt <= '0;
        end else if (r_state == StExec) begin
            r_cnt <= r_cnt + 3'd1;
        end
    end

    // Response registers; a zero magnitude always leaves as +0 with zf set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_r     <= '0;
            r_rsp_zf    <= 1'b0;
            r_rsp_sf    <= 1'b0;
        end else if (w_capture) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_r     <= w_zf ? '0 : w_r;
            r_rsp_zf    <= w_zf;
            r_rsp_sf    <= w_sf & ~w_zf;
        end else if (w_release) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_r     = r_rsp_r;
    assign rsp_zf    = r_rsp_zf;
    assign rsp_sf    = r_rsp_sf;

endmodule

// File: doc/alu_addsub_arbiter.md
Name: alu_addsub_arbiter

Overview:
Shares one add_sub datapath instance between two requesters. Each requester supplies an operation (add or sub) and two 3-bit sign-magnitude operands over a valid/ready handshake. The block arbitrates round-robin, sequences the operation through add_sub, and returns the 4-bit sign-magnitude result, its flags and the requester ID on one response channel. It sits between the ALU front-end clients and the add/sub execution unit.

Parameters:
EXEC_CYCLES, 1, number of cycles operands are held on add_sub before the result is captured (range 1..7).

Ports:
clk  input  1  clock; all logic on the rising edge
rst  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has an operation pending
req0_ready  output  1  requester 0 operation accepted this cycle
req0_op  input  1  0 = add (A+B), 1 = sub (A-B)
req0_a  input  3  operand A, sign-magnitude: bit2 sign, bits1:0 magnitude
req0_b  input  3  operand B, same format
req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0
rsp_valid  output  1  response holds a valid result
rsp_ready  input  1  consumer takes the response
rsp_id  output  1  requester that issued the operation
rsp_r  output  4  result, sign-magnitude: bit3 sign, bits2:0 magnitude
rsp_zf  output  1  result is zero
rsp_sf  output  1  result is negative

Behaviour:
- Reset: state=IDLE, rsp_valid=0, rsp_id=0, rsp_r=4'b0000, rsp_zf=0, rsp_sf=0, reqN_ready=0, last_grant=1, exec counter=0. Reset during any state drops the in-flight operation and produces no response.
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any reqN_valid, grant one; reqN_ready=1 combinationally for the granted requester only; in the same cycle latch op/a/b and the grant ID into operand registers; go to EXEC. Otherwise stay in IDLE.
- Arbitration: if only one is valid, grant it. If both are valid, grant the requester != last_grant. last_grant updates on every grant. After reset, requester 0 wins the first tie.
- reqN_ready is 0 in EXEC and RESP. Requesters hold valid/op/a/b stable until accepted.
- EXEC: operand registers drive add_sub (OP, A, B). The counter runs 1..EXEC_CYCLES. On the last count, capture R, ZF and SF into the rsp registers, set rsp_valid=1 and go to RESP.
- Latency: accept in cycle N gives rsp_valid=1 in cycle N+1+EXEC_CYCLES.
- Zero normalisation at capture: if R[2:0]==0, then rsp_r=4'b0000, rsp_zf=1 and rsp_sf=0, regardless of R[3] (no negative zero leaves the block). Otherwise rsp_sf=R[3] and rsp_zf=0.
- Operands are passed to add_sub unmodified, including -0 (3'b100).
- DZF from add_sub is ignored.
- RESP: all rsp_* outputs are held stable while rsp_valid=1 && rsp_ready=0. On rsp_ready=1, clear rsp_valid next cycle and go to IDLE. Data registers keep their last value.
- Throughput: at most one operation per 2+EXEC_CYCLES cycles. There is no new accept in the RESP cycle.
- Range: operands are -3..+3 and results are -6..+6, so no overflow handling is needed.

Decomposition:
- Shared package (alu_pkg):
  - OP_ADD=1'b0, OP_SUB=1'b1
  - operand width 3 and result width 4
  - FSM state encoding IDLE/EXEC/RESP
  - a zero-magnitude helper
- Sub-module: rr_arb2, the 2-way round-robin grant with its last_grant register.
- add_sub is instantiated unchanged.

Test Plan:
1. EXEC_CYCLES=1, req0 add A=3'b010 (+2) B=3'b011 (+3), rsp_ready=1 -> req0_ready high at N, rsp_valid at N+2, rsp_r=4'b0101, zf=0, sf=0, id=0.
2. After reset, both valid in the same cycle: req0 sub A=+1 B=+3, req1 add A=3'b111 (-3) B=+3. -> req0 is served first with rsp_r=4'b1010, sf=1, zf=0, id=0. req1 is then served with rsp_r=4'b0000, zf=1, sf=0, id=1.
3. Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* is unchanged each cycle, both readys stay 0, and req1 valid waits. Raising rsp_ready returns to IDLE and grants req1.
4. Negative zero: sub A=+2 B=+2 -> 4'b0000 with zf=1, sf=0. Add A=3'b100 (-0) B=3'b000 -> 4'b0000 with zf=1, sf=0. No 4'b1000 ever appears.
5. Assert rst for one cycle while in EXEC -> next cycle rsp_valid=0 and no response for that operation. With both requesters then valid, req0 is granted.
6. req1 valid continuously alone with rsp_ready=1, EXEC_CYCLES=3 -> req1_ready pulses every 5 cycles, and rsp_id=1 for each response.
